// File: rtl/vgpr_pkg.sv
// Shared VGPR bank constants and types, used by both the read-port arbiter and the write-port mux.
package vgpr_pkg;

    localparam int unsigned VGPR_ADDR_W       = 10;
    localparam int unsigned VGPR_DATA_W       = 2048;
    localparam int unsigned VGPR_NUM_RD_PORTS = 8;
    localparam int unsigned VGPR_SEL_W        = 16;
    localparam int unsigned VGPR_PORT_IDX_W   = $clog2(VGPR_NUM_RD_PORTS);

    typedef logic [VGPR_ADDR_W-1:0]     vgpr_addr_t;
    typedef logic [VGPR_DATA_W-1:0]     vgpr_data_t;
    typedef logic [VGPR_PORT_IDX_W-1:0] vgpr_port_idx_t;

endpackage

// File: rtl/vgpr_rd_port_arbiter_if.sv
// Client-request and bank-side signals of the VGPR read-port arbiter.
interface vgpr_rd_port_arbiter_if;
    import vgpr_pkg::*;

    logic [VGPR_NUM_RD_PORTS-1:0]             port_rd_req;
    logic [VGPR_NUM_RD_PORTS*VGPR_ADDR_W-1:0] port_rd_addr;
    logic [VGPR_NUM_RD_PORTS-1:0]             port_rd_gnt;
    logic                                     bank_rd_en;
    vgpr_addr_t                               bank_rd_addr;
    vgpr_data_t                               bank_rd_data;
    logic [VGPR_NUM_RD_PORTS-1:0]             port_rd_valid;
    vgpr_data_t                               port_rd_data;
    logic [VGPR_SEL_W-1:0]                    rd_port_select;

    modport master (
        output port_rd_req, port_rd_addr, bank_rd_data,
        input  port_rd_gnt, bank_rd_en, bank_rd_addr, port_rd_valid, port_rd_data, rd_port_select
    );

    modport slave (
        input  port_rd_req, port_rd_addr, bank_rd_data,
        output port_rd_gnt, bank_rd_en, bank_rd_addr, port_rd_valid, port_rd_data, rd_port_select
    );

endinterface

// File: rtl/vgpr_rr_arbiter.sv
// Eight-way round-robin arbiter: search starts one past the last winner, one-hot grant.
module vgpr_rr_arbiter
    import vgpr_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [VGPR_NUM_RD_PORTS-1:0] req,
    output logic [VGPR_NUM_RD_PORTS-1:0] gnt,
    output vgpr_port_idx_t               gnt_idx
);

    vgpr_port_idx_t last_q;
    vgpr_port_idx_t last_d;
    vgpr_port_idx_t idx;
    logic           found;

    always_comb begin
        found   = 1'b0;
        idx     = last_q;
        gnt_idx = last_q;
        gnt     = '0;
        // Offset 8 wraps back to last itself, so a lone requester wins every cycle.
        for (int i = 1; i <= VGPR_NUM_RD_PORTS; i++) begin
            idx = last_q + vgpr_port_idx_t'(i);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && rst_n) begin
            gnt[gnt_idx] = 1'b1;
        end
        last_d = (found && rst_n) ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= vgpr_port_idx_t'(VGPR_NUM_RD_PORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vgpr_rd_port_arbiter.sv
// VGPR read-port arbiter: grants one client per cycle, issues to the bank, and routes the
// returned data back to its requester through a one-hot tag pipe matched to the bank latency.
module vgpr_rd_port_arbiter
    import vgpr_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vgpr_rd_port_arbiter_if.slave  bus
);

    logic [VGPR_NUM_RD_PORTS-1:0] gnt;
    vgpr_port_idx_t               gnt_idx;
    vgpr_addr_t                   gnt_addr;

    logic                         en_q;
    vgpr_addr_t                   addr_q;
    logic [VGPR_NUM_RD_PORTS-1:0] sel_q;
    logic [VGPR_NUM_RD_PORTS-1:0] tag_q [RD_LATENCY];
    logic [VGPR_NUM_RD_PORTS-1:0] valid;

    vgpr_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.port_rd_req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        gnt_addr = bus.port_rd_addr[32'(gnt_idx) * VGPR_ADDR_W +: VGPR_ADDR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            sel_q  <= '0;
        end else begin
            en_q  <= |gnt;
            sel_q <= gnt;
            if (|gnt) begin
                addr_q <= gnt_addr;
            end
        end
    end

    // One stage per bank-latency cycle; the last stage lines up with bank_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= sel_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        valid             = tag_q[RD_LATENCY-1];
        bus.port_rd_gnt   = gnt;
        bus.bank_rd_en    = en_q;
        bus.bank_rd_addr  = addr_q;
        bus.rd_port_select = {{(VGPR_SEL_W - VGPR_NUM_RD_PORTS){1'b0}}, sel_q};
        bus.port_rd_valid = valid;
        bus.port_rd_data  = (|valid) ? bus.bank_rd_data : '0;
    end

endmodule

// File: tb/tb_vgpr_rd_port_arbiter.sv
// Directed bench for vgpr_rd_port_arbiter with one instance at RD_LATENCY=1 and one at 3.
module tb_vgpr_rd_port_arbiter;
    import vgpr_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    vgpr_rd_port_arbiter_if ifa ();
    vgpr_rd_port_arbiter_if ifb ();

    vgpr_rd_port_arbiter #(.RD_LATENCY(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    vgpr_rd_port_arbiter #(.RD_LATENCY(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    function automatic vgpr_data_t make_data(input vgpr_addr_t a);
        return {64{6'h2b, a, 6'h15, a}};
    endfunction

    // Bank models: data for the address issued RD_LATENCY cycles earlier.
    vgpr_addr_t a_pipe;
    vgpr_addr_t b_pipe [3];
    always @(posedge clk) begin
        a_pipe    <= ifa.bank_rd_addr;
        b_pipe[0] <= ifb.bank_rd_addr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign ifa.bank_rd_data = make_data(a_pipe);
    assign ifb.bank_rd_data = make_data(b_pipe[2]);

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_addr_a(input int p, input vgpr_addr_t a);
        ifa.port_rd_addr[p*VGPR_ADDR_W +: VGPR_ADDR_W] = a;
    endtask

    task automatic set_addr_b(input int p, input vgpr_addr_t a);
        ifb.port_rd_addr[p*VGPR_ADDR_W +: VGPR_ADDR_W] = a;
    endtask

    task automatic pulse_reset();
        ifa.port_rd_req = '0;
        ifb.port_rd_req = '0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.port_rd_req = 8'hff;
        ifb.port_rd_req = 8'hff;
        for (int c = 0; c < 2; c++) begin
            if (c == 1) next_cycle();
            #1;
            if (ifa.port_rd_gnt !== 8'h00) begin
                $display("FAIL reset gnt_a c%0d got %h want 00", c, ifa.port_rd_gnt); miscompares++;
            end
            vectors++;
            if (ifb.port_rd_gnt !== 8'h00) begin
                $display("FAIL reset gnt_b c%0d got %h want 00", c, ifb.port_rd_gnt); miscompares++;
            end
            vectors++;
            if ({ifa.bank_rd_en, ifa.bank_rd_addr, ifa.rd_port_select, ifa.port_rd_valid} !== '0) begin
                $display("FAIL reset regs_a c%0d got en=%b addr=%h sel=%h vld=%h want all 0", c,
                         ifa.bank_rd_en, ifa.bank_rd_addr, ifa.rd_port_select, ifa.port_rd_valid);
                miscompares++;
            end
            vectors++;
            if (ifa.port_rd_data !== '0) begin
                $display("FAIL reset data_a c%0d got %h want 0", c, ifa.port_rd_data[63:0]);
                miscompares++;
            end
            vectors++;
        end
        ifa.port_rd_req = '0;
        ifb.port_rd_req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        logic [7:0]  e_gnt, e_vld;
        logic [15:0] e_sel;
        vgpr_data_t  e_data;
        set_addr_a(3, 10'h155);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            ifa.port_rd_req = (c == 0) ? 8'h08 : 8'h00;
            #1;
            e_gnt  = (c == 0) ? 8'h08 : 8'h00;
            e_sel  = (c == 1) ? 16'h0008 : 16'h0000;
            e_vld  = (c == 2) ? 8'h08 : 8'h00;
            e_data = (c == 2) ? make_data(10'h155) : '0;
            if (ifa.port_rd_gnt !== e_gnt) begin
                $display("FAIL single gnt c%0d got %h want %h", c, ifa.port_rd_gnt, e_gnt); miscompares++;
            end
            vectors++;
            if (ifa.bank_rd_en !== (c == 1) || ifa.rd_port_select !== e_sel) begin
                $display("FAIL single issue c%0d got en=%b sel=%h want en=%b sel=%h", c,
                         ifa.bank_rd_en, ifa.rd_port_select, (c == 1), e_sel);
                miscompares++;
            end
            vectors++;
            if (c >= 1) begin
                if (ifa.bank_rd_addr !== 10'h155) begin
                    $display("FAIL single addr c%0d got %h want 155", c, ifa.bank_rd_addr); miscompares++;
                end
                vectors++;
            end
            if (ifa.port_rd_valid !== e_vld || ifa.port_rd_data !== e_data) begin
                $display("FAIL single return c%0d got vld=%h data=%h want vld=%h data=%h", c,
                         ifa.port_rd_valid, ifa.port_rd_data[63:0], e_vld, e_data[63:0]);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_all_ports();
        logic [7:0]  e_gnt, e_vld;
        logic [15:0] e_sel;
        logic        e_en;
        vgpr_data_t  e_data;
        pulse_reset();
        for (int p = 0; p < 8; p++) set_addr_a(p, 10'(10'h100 + p));
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            ifa.port_rd_req = (c < 10) ? 8'hff : 8'h00;
            #1;
            e_gnt  = (c < 10) ? 8'(1 << (c % 8)) : 8'h00;
            e_en   = (c >= 1 && c <= 10);
            e_sel  = e_en ? 16'(1 << ((c - 1) % 8)) : 16'h0000;
            e_vld  = (c >= 2) ? 8'(1 << ((c - 2) % 8)) : 8'h00;
            e_data = (c >= 2) ? make_data(10'(10'h100 + (c - 2) % 8)) : '0;
            if (ifa.port_rd_gnt !== e_gnt) begin
                $display("FAIL allports gnt c%0d got %h want %h", c, ifa.port_rd_gnt, e_gnt); miscompares++;
            end
            vectors++;
            if (ifa.bank_rd_en !== e_en || ifa.rd_port_select !== e_sel) begin
                $display("FAIL allports issue c%0d got en=%b sel=%h want en=%b sel=%h", c,
                         ifa.bank_rd_en, ifa.rd_port_select, e_en, e_sel);
                miscompares++;
            end
            vectors++;
            if (e_en) begin
                if (ifa.bank_rd_addr !== 10'(10'h100 + (c - 1) % 8)) begin
                    $display("FAIL allports addr c%0d got %h want %h", c, ifa.bank_rd_addr,
                             10'(10'h100 + (c - 1) % 8));
                    miscompares++;
                end
                vectors++;
            end
            if (ifa.port_rd_valid !== e_vld || ifa.port_rd_data !== e_data) begin
                $display("FAIL allports return c%0d got vld=%h data=%h want vld=%h data=%h", c,
                         ifa.port_rd_valid, ifa.port_rd_data[63:0], e_vld, e_data[63:0]);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  e_gnt, e_vld;
        logic [15:0] e_sel;
        logic        e_en;
        vgpr_data_t  e_data;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (c < 3) set_addr_a(2, 10'(10'h010 + c));
            ifa.port_rd_req = (c < 3) ? 8'h04 : 8'h00;
            #1;
            e_gnt  = (c < 3) ? 8'h04 : 8'h00;
            e_en   = (c >= 1 && c <= 3);
            e_sel  = e_en ? 16'h0004 : 16'h0000;
            e_vld  = (c >= 2 && c <= 4) ? 8'h04 : 8'h00;
            e_data = (c >= 2 && c <= 4) ? make_data(10'(10'h010 + c - 2)) : '0;
            if (ifa.port_rd_gnt !== e_gnt) begin
                $display("FAIL b2b gnt c%0d got %h want %h", c, ifa.port_rd_gnt, e_gnt); miscompares++;
            end
            vectors++;
            if (ifa.bank_rd_en !== e_en || ifa.rd_port_select !== e_sel) begin
                $display("FAIL b2b issue c%0d got en=%b sel=%h want en=%b sel=%h", c,
                         ifa.bank_rd_en, ifa.rd_port_select, e_en, e_sel);
                miscompares++;
            end
            vectors++;
            // Address holds the last issued value once the strobe drops.
            if (c >= 1) begin
                if (ifa.bank_rd_addr !== 10'(10'h010 + ((c > 3) ? 2 : c - 1))) begin
                    $display("FAIL b2b addr c%0d got %h want %h", c, ifa.bank_rd_addr,
                             10'(10'h010 + ((c > 3) ? 2 : c - 1)));
                    miscompares++;
                end
                vectors++;
            end
            if (ifa.port_rd_valid !== e_vld || ifa.port_rd_data !== e_data) begin
                $display("FAIL b2b return c%0d got vld=%h data=%h want vld=%h data=%h", c,
                         ifa.port_rd_valid, ifa.port_rd_data[63:0], e_vld, e_data[63:0]);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_latency3();
        logic [7:0]  e_gnt, e_vld;
        logic [15:0] e_sel;
        vgpr_data_t  e_data;
        set_addr_b(1, 10'h0a1);
        set_addr_b(5, 10'h0a5);
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            ifb.port_rd_req = (c == 0) ? 8'h22 : (c == 1) ? 8'h20 : 8'h00;
            #1;
            e_gnt  = (c == 0) ? 8'h02 : (c == 1) ? 8'h20 : 8'h00;
            e_sel  = (c == 1) ? 16'h0002 : (c == 2) ? 16'h0020 : 16'h0000;
            e_vld  = (c == 4) ? 8'h02 : (c == 5) ? 8'h20 : 8'h00;
            e_data = (c == 4) ? make_data(10'h0a1) : (c == 5) ? make_data(10'h0a5) : '0;
            if (ifb.port_rd_gnt !== e_gnt) begin
                $display("FAIL lat3 gnt c%0d got %h want %h", c, ifb.port_rd_gnt, e_gnt); miscompares++;
            end
            vectors++;
            if (ifb.bank_rd_en !== (c == 1 || c == 2) || ifb.rd_port_select !== e_sel) begin
                $display("FAIL lat3 issue c%0d got en=%b sel=%h want en=%b sel=%h", c,
                         ifb.bank_rd_en, ifb.rd_port_select, (c == 1 || c == 2), e_sel);
                miscompares++;
            end
            vectors++;
            if (c >= 1) begin
                if (ifb.bank_rd_addr !== ((c == 1) ? 10'h0a1 : 10'h0a5)) begin
                    $display("FAIL lat3 addr c%0d got %h want %h", c, ifb.bank_rd_addr,
                             (c == 1) ? 10'h0a1 : 10'h0a5);
                    miscompares++;
                end
                vectors++;
            end
            if (ifb.port_rd_valid !== e_vld || ifb.port_rd_data !== e_data) begin
                $display("FAIL lat3 return c%0d got vld=%h data=%h want vld=%h data=%h", c,
                         ifb.port_rd_valid, ifb.port_rd_data[63:0], e_vld, e_data[63:0]);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_reset_in_flight();
        // ifb last is 5 here, so port 0 wins ahead of port 1.
        set_addr_b(0, 10'h3c0);
        set_addr_b(1, 10'h3c1);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            ifb.port_rd_req = (c == 0) ? 8'h03 : (c == 1) ? 8'h02 : 8'h00;
            #1;
            if (ifb.port_rd_gnt !== ((c == 0) ? 8'h01 : (c == 1) ? 8'h02 : 8'h00)) begin
                $display("FAIL rstfly gnt c%0d got %h want %h", c, ifb.port_rd_gnt,
                         (c == 0) ? 8'h01 : (c == 1) ? 8'h02 : 8'h00);
                miscompares++;
            end
            vectors++;
        end
        if (ifb.rd_port_select !== 16'h0002) begin
            $display("FAIL rstfly presel got %h want 0002", ifb.rd_port_select); miscompares++;
        end
        vectors++;
        ifb.port_rd_req = 8'h03;
        rst_n = 1'b0;
        #1;
        if ({ifb.port_rd_gnt, ifb.bank_rd_en, ifb.bank_rd_addr, ifb.rd_port_select,
             ifb.port_rd_valid} !== '0 || ifb.port_rd_data !== '0) begin
            $display("FAIL rstfly async got gnt=%h en=%b addr=%h sel=%h vld=%h want all 0",
                     ifb.port_rd_gnt, ifb.bank_rd_en, ifb.bank_rd_addr, ifb.rd_port_select,
                     ifb.port_rd_valid);
            miscompares++;
        end
        vectors++;
        next_cycle();
        ifb.port_rd_req = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            #1;
            if (ifb.port_rd_valid !== 8'h00 || ifb.bank_rd_en !== 1'b0 || ifb.port_rd_data !== '0) begin
                $display("FAIL rstfly stale c%0d got vld=%h en=%b data=%h want 0", c,
                         ifb.port_rd_valid, ifb.bank_rd_en, ifb.port_rd_data[63:0]);
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_idle_hold();
        next_cycle();
        ifa.port_rd_req = 8'h10;
        #1;
        if (ifa.port_rd_gnt !== 8'h10) begin
            $display("FAIL idle gnt4 got %h want 10", ifa.port_rd_gnt); miscompares++;
        end
        vectors++;
        next_cycle();
        ifa.port_rd_req = '0;
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            if ({ifa.port_rd_gnt, ifa.bank_rd_en, ifa.rd_port_select, ifa.port_rd_valid} !== '0 ||
                ifa.port_rd_data !== '0) begin
                $display("FAIL idle quiet c%0d got gnt=%h en=%b sel=%h vld=%h want all 0", c,
                         ifa.port_rd_gnt, ifa.bank_rd_en, ifa.rd_port_select, ifa.port_rd_valid);
                miscompares++;
            end
            vectors++;
        end
        // last must still be 4 after the idle stretch.
        next_cycle();
        ifa.port_rd_req = 8'hff;
        #1;
        if (ifa.port_rd_gnt !== 8'h20) begin
            $display("FAIL idle lasthold got %h want 20", ifa.port_rd_gnt); miscompares++;
        end
        vectors++;
        next_cycle();
        ifa.port_rd_req = '0;
    endtask

    initial begin
        ifa.port_rd_req  = '0;
        ifa.port_rd_addr = '0;
        ifb.port_rd_req  = '0;
        ifb.port_rd_addr = '0;
        test_reset();
        test_single_read();
        test_all_ports();
        test_back_to_back();
        test_latency3();
        test_reset_in_flight();
        test_idle_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vgpr_rd_port_arbiter.md
# vgpr_rd_port_arbiter

Read-side counterpart of the VGPR write-port mux. Eight clients (ALU operand fetch, LSU store data, etc.) raise read requests. The block grants one request per cycle with round-robin fairness and issues the read to the VGPR bank. It tracks each in-flight read and returns the bank data to the requesting client with a one-hot valid.

## Interface
Parameters:
- RD_LATENCY, 1: cycles from `bank_rd_en` to `bank_rd_data` being valid; legal range 1–4.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `port_rd_req`  in  8  per-client read request; bit i belongs to port i.
- `port_rd_addr`  in  80  per-client VGPR address; port i occupies [10i+9:10i].
- `port_rd_gnt`  out  8  one-hot grant; combinational, same cycle as the request.
- `bank_rd_en`  out  1  registered read strobe to the VGPR bank.
- `bank_rd_addr`  out  10  registered read address to the bank.
- `bank_rd_data`  in  2048  bank read data, valid RD_LATENCY cycles after `bank_rd_en`.
- `port_rd_valid`  out  8  one-hot: returned data belongs to port i.
- `port_rd_data`  out  2048  shared return bus, zero when no valid bit is set.
- `rd_port_select`  out  16  registered one-hot of the issuing port in [7:0]; [15:8] always 0. Same encoding as the write-side select.

## Operation
- Handshake: a client holds `port_rd_req[i]` high with a stable address until it sees `port_rd_req[i] & port_rd_gnt[i]` in a cycle. It may then drop the request, or keep it high with a new address for another read.
- Arbitration:
  - 3-bit pointer `last`; search order starts at `last+1` and wraps modulo 8.
  - The first requesting port wins. At most one grant bit is set per cycle.
  - On a grant, `last` takes the granted index at the clock edge. With no requests, the grant is 0 and `last` holds.
- Issue: on the edge after a grant to port g:
  - `bank_rd_en` = 1, `bank_rd_addr` = `port_rd_addr[g]`, `rd_port_select` = 1<<g.
  - With no grant: `bank_rd_en` = 0, `rd_port_select` = 0, `bank_rd_addr` holds its last value.
- Tag pipe:
  - An 8-bit one-hot tag shift register, RD_LATENCY stages deep.
  - Stage 0 loads `rd_port_select[7:0]` each cycle; a stage is all zeros when no read is in flight.
  - `port_rd_valid` is the final stage.
  - `port_rd_data` = `bank_rd_data` when any valid bit is set, else 0.
- Throughput: one read per cycle sustained. Any tag in flight is never overwritten or dropped.

## Timing
- Grant in cycle t → bank issue in cycle t+1 → `port_rd_valid`/`port_rd_data` in cycle t+1+RD_LATENCY.
- Reset values (asynchronous on `rst_n` low):
  - `last` = 7, so port 0 has first priority.
  - `bank_rd_en` = 0, `bank_rd_addr` = 0, `rd_port_select` = 0.
  - All tag stages = 0, so `port_rd_valid` = 0 and `port_rd_data` = 0.
  - `port_rd_gnt` = 0 while `rst_n` is low, regardless of requests.
- Reset mid-operation: all in-flight reads are discarded and no valid is ever produced for them. Clients must re-request after reset is released.
- Simultaneous requests from all 8 ports: grants rotate 0,1,…,7,0 in consecutive cycles. No port waits more than 7 cycles.
- A single requester holding `req` high is granted every cycle.
- A request that drops before it is granted is simply withdrawn; no state is kept for it.
- Wrap: after `last` = 7 the search starts at port 0.

## Structure
- Shared package `vgpr_pkg`:
  - `VGPR_ADDR_W`=10, `VGPR_DATA_W`=2048, `VGPR_NUM_RD_PORTS`=8, `VGPR_SEL_W`=16.
  - `vgpr_addr_t` and `vgpr_data_t` typedefs.
  - Also used by the write-port mux.
- One sub-module, `vgpr_rr_arbiter`: 8-request round-robin arbiter holding `last`, with one-hot grant output. The top level holds the issue registers and the tag pipe.

## Test plan
- Reset, then port 3 requests address 0x155 with RD_LATENCY=1 → `port_rd_gnt`=0x08 in cycle t. In t+1: `bank_rd_en`=1, `bank_rd_addr`=0x155, `rd_port_select`=0x0008. In t+2: `port_rd_valid`=0x08 and `port_rd_data` = bank data.
- All 8 ports request continuously from reset → grants 0x01,0x02,…,0x80,0x01. Valids follow the same order, each RD_LATENCY+1 cycles after its grant.
- Port 2 alone holds `req` for 3 cycles with addresses 0x010, 0x011, 0x012 → 3 consecutive grants. The bank sees 3 back-to-back addresses, and 3 consecutive `port_rd_valid`=0x04 beats carry the matching data.
- RD_LATENCY=3, ports 1 and 5 request together with `last`=7 → port 1 is granted first, then port 5. Valids are 0x02 then 0x20 in cycles t+4 and t+5.
- Assert `rst_n` low while 2 reads are in flight → all outputs go to 0 immediately. After release, no stale `port_rd_valid` appears.
- Idle with no requests for 10 cycles → `bank_rd_en`=0, `rd_port_select`=0, `port_rd_valid`=0, `port_rd_data`=0, and `last` unchanged.
